// File: rtl/mem_master.sv
// Bus initiator for an 8-bit synchronous single-port RAM: turns 1- or 2-byte
// read/write requests into registered RAM bus cycles and returns a one-cycle response.
module mem_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_len,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  rsp_valid,
    output logic [2*DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic                  len_q, len_d;
    logic [DATA_W-1:0]     wdata_hi_q, wdata_hi_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            len_q       <= 1'b0;
            wdata_hi_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            len_q       <= len_d;
            wdata_hi_q  <= wdata_hi_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Bus strobes default to idle each cycle; only the byte-load states reassert them.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        len_d       = len_q;
        wdata_hi_d  = wdata_hi_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    len_d       = req_len;
                    wdata_hi_d  = req_wdata[2*DATA_W-1:DATA_W];
                    mem_addr_d  = req_addr;
                    mem_we_d    = req_we;
                    mem_wdata_d = req_we ? req_wdata[DATA_W-1:0] : '0;
                    state_d     = S_ACC0;
                end
            end
            S_ACC0: begin
                if (len_q) begin
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                    mem_we_d    = we_q;
                    mem_wdata_d = we_q ? wdata_hi_q : '0;
                    state_d     = S_ACC1;
                end else if (we_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACC1: begin
                if (we_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    // RAM output now carries byte A (addressed during ACC0).
                    rsp_rdata_d[DATA_W-1:0] = mem_rdata;
                    state_d                 = S_WAIT;
                end
            end
            S_WAIT: begin
                if (len_q) begin
                    rsp_rdata_d[2*DATA_W-1:DATA_W] = mem_rdata;
                end else begin
                    rsp_rdata_d = {{DATA_W{1'b0}}, mem_rdata};
                end
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: directed requests against a behavioural
// synchronous RAM, with a scoreboard queue checked by an independent response monitor.
module tb_mem_master;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic         req_len;
    logic [11:0]  req_addr;
    logic [15:0]  req_wdata;
    logic         rsp_valid;
    logic [15:0]  rsp_rdata;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_we;
    logic [7:0]   mem_rdata;

    mem_master #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_len   (req_len),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency; preloaded on the first edge.
    logic [7:0] ram [0:4095];
    logic       ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'(i) ^ 8'hC3;
            ram[12'h000] <= 8'h10;
            ram[12'h004] <= 8'h80;
            ram[12'h005] <= 8'h01;
            ram[12'h011] <= 8'h22;
            ram[12'h101] <= 8'h33;
            ram_loaded   <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    endtask

    typedef struct {
        logic [15:0] rdata;
        int          edge_n;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin : rsp_monitor
        exp_t e;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: rsp_valid=1 at edge %0d, required no response", cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
                check({e.name, "_latency"}, cyc, e.edge_n);
            end
        end
    end

    typedef struct {
        int          c;
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wr_log[$];
    int  wdata_viol = 0;
    int  acc_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) wr_log.push_back('{cyc, mem_addr, mem_wdata});
        else if (mem_wdata != 8'h00) wdata_viol++;
        if (req_valid && req_ready && !reset) acc_cnt++;
    end

    task automatic do_req(input string name, input logic we, input logic len,
                          input logic [11:0] addr, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input int lat,
                          input bit push_exp, input bit hold, output int acc);
        int waited = 0;
        acc = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_len   = len;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_total++;
            $display("FAIL %s_accept: req_ready=0 after %0d cycles, required 1", name, waited);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (push_exp) exp_q.push_back('{exp_rd, acc + lat, name});
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_total++;
            $display("FAIL %s_idle: req_ready=0 after %0d cycles, required 1", name, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int acc, acc2, a0, n_low;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_len   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single-byte read at 0x000
        do_req("rd0", 1'b0, 1'b0, 12'h000, 16'h0000, 16'h0010, 2, 1'b1, 1'b0, acc);
        @(negedge clk);
        check("rd0_addr", 32'(mem_addr), 32'h000);
        check("rd0_we", 32'(mem_we), 32'h0);
        n_low = 0;
        while (!req_ready && n_low < 20) begin
            n_low++;
            @(negedge clk);
        end
        check("rd0_busy_cycles", n_low, 3);

        // Two-byte read at 0x004
        do_req("rd1", 1'b0, 1'b1, 12'h004, 16'h0000, 16'h0180, 3, 1'b1, 1'b0, acc);
        @(negedge clk);
        check("rd1_addr0", 32'(mem_addr), 32'h004);
        @(negedge clk);
        check("rd1_addr1", 32'(mem_addr), 32'h005);
        wait_idle("rd1");
        check("rd1_addr_hold", 32'(mem_addr), 32'h005);

        // Two-byte write wrapping at the top of the address space
        wr_log.delete();
        do_req("wr_fff", 1'b1, 1'b1, 12'hFFF, 16'hBEEF, 16'h0180, 2, 1'b1, 1'b0, acc);
        wait_idle("wr_fff");
        check("wr_fff_we_cycles", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("wr_fff_b0_cyc", wr_log[0].c, acc);
            check("wr_fff_b0_addr", 32'(wr_log[0].a), 32'hFFF);
            check("wr_fff_b0_data", 32'(wr_log[0].d), 32'hEF);
            check("wr_fff_b1_cyc", wr_log[1].c, acc + 1);
            check("wr_fff_b1_addr", 32'(wr_log[1].a), 32'h000);
            check("wr_fff_b1_data", 32'(wr_log[1].d), 32'hBE);
        end
        do_req("rd_fff", 1'b0, 1'b1, 12'hFFF, 16'h0000, 16'hBEEF, 3, 1'b1, 1'b0, acc);
        wait_idle("rd_fff");

        // Back-to-back requests with req_valid held high throughout
        wr_log.delete();
        a0 = acc_cnt;
        do_req("b2b_a", 1'b1, 1'b1, 12'h020, 16'h1234, 16'hBEEF, 2, 1'b1, 1'b1, acc);
        do_req("b2b_b", 1'b1, 1'b0, 12'h030, 16'h0056, 16'hBEEF, 1, 1'b1, 1'b0, acc2);
        wait_idle("b2b");
        check("b2b_accepts", acc_cnt - a0, 2);
        check("b2b_second_accept_edge", acc2, acc + 4);
        check("b2b_we_cycles", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("b2b_second_bus_cyc", wr_log[2].c, acc + 4);
            check("b2b_second_bus_addr", 32'(wr_log[2].a), 32'h030);
            check("b2b_second_bus_data", 32'(wr_log[2].d), 32'h56);
        end

        // Asynchronous reset during ACC1 of a two-byte write
        do_req("wr_abort", 1'b1, 1'b1, 12'h100, 16'h5AA5, 16'h0000, 0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        check("abort_we_in_acc1", 32'(mem_we), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_we_dropped", 32'(mem_we), 32'h0);
        check("abort_ready_in_reset", 32'(req_ready), 32'h1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        check("abort_mem_addr", 32'(mem_addr), 32'h000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(req_ready), 32'h1);
        check("abort_ram_a", 32'(ram[12'h100]), 32'hA5);
        check("abort_ram_a1", 32'(ram[12'h101]), 32'h33);

        // Write then immediate reads of the same byte
        do_req("wr010", 1'b1, 1'b0, 12'h010, 16'hAA7F, 16'h0000, 1, 1'b1, 1'b0, acc);
        do_req("rd010_len1", 1'b0, 1'b1, 12'h010, 16'h0000, 16'h227F, 3, 1'b1, 1'b0, acc);
        do_req("rd010_len0", 1'b0, 1'b0, 12'h010, 16'h0000, 16'h007F, 2, 1'b1, 1'b0, acc);
        wait_idle("rd010");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("wdata_zero_outside_writes", wdata_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
